// File: rtl/wb_regfile.sv
// Purpose: 32 x 32-bit general register file; WB write port, two ID read ports with WB->ID bypass, debug read port.
// Latency: reads are combinational (zero cycles); a write commits at the rising clk edge.
// Backpressure: none; one write-back beat is accepted every cycle.
module wb_regfile #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wn,
  input  logic [WIDTH-1:0]      d,
  input  logic [DEPTH_LOG2-1:0] rna,
  input  logic [DEPTH_LOG2-1:0] rnb,
  output logic [WIDTH-1:0]      qa,
  output logic [WIDTH-1:0]      qb,
  input  logic [DEPTH_LOG2-1:0] dbg_rn,
  output logic [WIDTH-1:0]      dbg_q,
  output logic [15:0]           wr_cnt
);

  localparam int NREG = 1 << DEPTH_LOG2;

  // Entry 0 is reset with the rest and never written, so it stays a constant zero.
  logic [WIDTH-1:0] regs_q [NREG];
  logic [15:0]      wr_cnt_q;
  logic [15:0]      wr_cnt_d;
  logic             commit;

  // A write to register 0 is architecturally a no-op, so it neither stores nor counts.
  assign commit = we && (wn != '0);

  // Committed-write counter; wraps naturally at 16 bits.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // Register array and counter; clr clears everything without waiting for clk.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      if (commit) begin
        regs_q[wn] <= d;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Port A: zero for r0 or during clr, else the in-flight WB data on a match, else stored value.
  always_comb begin
    qa = '0;
    if (!clr && (rna != '0)) begin
      qa = (commit && (wn == rna)) ? d : regs_q[rna];
    end
  end

  // Port B: same selection as port A, driven by rnb.
  always_comb begin
    qb = '0;
    if (!clr && (rnb != '0)) begin
      qb = (commit && (wn == rnb)) ? d : regs_q[rnb];
    end
  end

  // Debug port shows committed contents only, never the bypass value.
  always_comb begin
    dbg_q = '0;
    if (!clr && (dbg_rn != '0)) begin
      dbg_q = regs_q[dbg_rn];
    end
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: scoreboard of expected port values, drained after inputs settle.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [4:0]  dbg_rn;
  logic [31:0] dbg_q;
  logic [15:0] wr_cnt;

  wb_regfile #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk(clk), .clr(clr), .we(we), .wn(wn), .d(d),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .dbg_rn(dbg_rn), .dbg_q(dbg_q), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;   // 0=qa 1=qb 2=dbg_q 3=wr_cnt
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem [32];
  logic [15:0] cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = qa;
        1:       obs = qb;
        2:       obs = dbg_q;
        default: obs = {16'h0, wr_cnt};
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] m_q(input logic [4:0] rn);
    if (clr || rn == 5'd0) return 32'h0;
    if (we && wn == rn) return d;
    return mem[rn];
  endfunction

  function automatic logic [31:0] m_dbg(input logic [4:0] rn);
    if (clr || rn == 5'd0) return 32'h0;
    return mem[rn];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    cnt = 16'h0;
  endtask

  // Advance one edge, updating the model with whatever the held inputs commit.
  task automatic step();
    if (!clr && we && wn != 5'd0) begin
      mem[wn] = d;
      cnt     = cnt + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] n, input logic [31:0] v);
    we = 1'b1; wn = n; d = v;
    step();
    we = 1'b0;
  endtask

  task automatic push_all(input string tag);
    push({tag, "_qa"}, 0, m_q(rna));
    push({tag, "_qb"}, 1, m_q(rnb));
    push({tag, "_dbg"}, 2, m_dbg(dbg_rn));
    push({tag, "_cnt"}, 3, {16'h0, cnt});
  endtask

  initial begin
    clr = 1'b1; we = 1'b0; wn = '0; d = '0; rna = 5'd5; rnb = 5'd31; dbg_rn = 5'd5;
    m_reset();

    // Reset state
    #2;
    push("rst_qa", 0, 32'h0); push("rst_qb", 1, 32'h0);
    push("rst_dbg", 2, 32'h0); push("rst_cnt", 3, 32'h0);
    drain();
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    // 1: reset mid-operation
    wr(5'd5, 32'hDEADBEEF);
    push("t1_pre_dbg", 2, 32'hDEADBEEF); push("t1_pre_cnt", 3, 32'h1);
    drain();
    we = 1'b1; wn = 5'd5; d = 32'h12345678; rna = 5'd5;
    #1;
    clr = 1'b1;
    m_reset();
    push("t1_clr_qa", 0, 32'h0); push("t1_clr_dbg", 2, 32'h0); push("t1_clr_cnt", 3, 32'h0);
    drain();
    #1;
    clr = 1'b0;
    step();
    we = 1'b0;
    push("t1_post_dbg", 2, 32'h12345678); push("t1_post_cnt", 3, 32'h1);
    drain();

    // 2: r0 immutability
    we = 1'b1; wn = 5'd0; d = 32'hFFFFFFFF; rna = 5'd0; dbg_rn = 5'd0;
    for (int k = 0; k < 3; k++) begin
      push($sformatf("t2_qa%0d", k), 0, 32'h0);
      push($sformatf("t2_dbg%0d", k), 2, 32'h0);
      push($sformatf("t2_cnt%0d", k), 3, 32'h1);
      drain();
      step();
    end
    we = 1'b0;
    push("t2_end_qa", 0, 32'h0); push("t2_end_cnt", 3, 32'h1);
    drain();

    // 3: bypass
    wr(5'd7, 32'h00000011);
    we = 1'b1; wn = 5'd7; d = 32'h00000022; rna = 5'd7; rnb = 5'd7; dbg_rn = 5'd7;
    push("t3_byp_qa", 0, 32'h22); push("t3_byp_qb", 1, 32'h22); push("t3_byp_dbg", 2, 32'h11);
    drain();
    step();
    we = 1'b0;
    push("t3_aft_qa", 0, 32'h22); push("t3_aft_qb", 1, 32'h22); push("t3_aft_dbg", 2, 32'h22);
    push("t3_aft_cnt", 3, 32'h3);
    drain();

    // 4: independent ports
    for (int n = 1; n < 32; n++) wr(5'(n), 32'h1000 + 32'(n));
    for (int n = 0; n < 32; n++) begin
      rna = 5'(n); rnb = 5'(31 - n); dbg_rn = 5'(n);
      push($sformatf("t4_qa%0d", n), 0, (n == 0) ? 32'h0 : 32'h1000 + 32'(n));
      push($sformatf("t4_qb%0d", n), 1, (n == 31) ? 32'h0 : 32'h1000 + 32'(31 - n));
      drain();
    end

    // 5: write-enable gating
    we = 1'b0; wn = 5'd9; d = 32'hCAFEF00D; rna = 5'd9; dbg_rn = 5'd9;
    push("t5_pre_qa", 0, 32'h00001009);
    drain();
    step();
    push("t5_post_qa", 0, 32'h00001009); push("t5_post_dbg", 2, 32'h00001009);
    push("t5_post_cnt", 3, 32'd34);
    drain();

    // Randomised mix against the model
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1)); wn = 5'($urandom); d = $urandom;
      rna = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
      rnb = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
      dbg_rn = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
      push_all("rnd");
      drain();
      step();
    end
    we = 1'b0;

    // 6: counter wrap from a fresh reset
    #1; clr = 1'b1; m_reset(); #1; clr = 1'b0;
    push("t6_rst_cnt", 3, 32'h0);
    drain();
    we = 1'b1; wn = 5'd3; dbg_rn = 5'd3;
    for (int i = 0; i < 65536; i++) begin
      d = 32'(i);
      step();
      if (i == 65534) begin
        push("t6_ffff_cnt", 3, 32'h0000FFFF);
        drain();
      end
    end
    we = 1'b0;
    push("t6_wrap_cnt", 3, 32'h0); push("t6_r3", 2, 32'h0000FFFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- 32 x 32-bit general register file that sinks the write-back stream driven by the MEM/WB pipeline latch (write-enable, destination number, result).
- Serves two asynchronous read ports to the ID stage.
- Internal write-to-read bypass, so an ID-stage read in the same cycle as a WB write to that register returns the new value; no extra forwarding path is needed for the WB->ID distance.
- Third read-only debug port for bench/board inspection.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH_LOG2, 5, register-number width (2^DEPTH_LOG2 registers).

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- clr  input  1  asynchronous, active-high reset; clears every register.
- we  input  1  write enable, from MEM/WB wreg output.
- wn  input  DEPTH_LOG2  destination register number, from MEM/WB wn output.
- d  input  WIDTH  write data, from MEM/WB res output.
- rna  input  DEPTH_LOG2  read port A register number (rs).
- rnb  input  DEPTH_LOG2  read port B register number (rt).
- qa  output  WIDTH  read port A data.
- qb  output  WIDTH  read port B data.
- dbg_rn  input  DEPTH_LOG2  debug read register number.
- dbg_q  output  WIDTH  debug read data, raw array contents.
- wr_cnt  output  16  count of committed writes since reset.

Behaviour:
- Reset:
  - clr=1 asynchronously forces registers 1..31 to 0 and wr_cnt to 0, independent of clk.
  - While clr=1, qa, qb and dbg_q read 0 for every register number.
  - Bypass is suppressed while clr=1.
  - Release of clr takes effect at the next rising edge; a write presented in that edge commits.
- Register 0:
  - Not stored; every read of number 0 returns 0 on all ports.
  - A write with wn=0 is discarded, the bypass never fires for register 0, and wr_cnt does not increment.
- Write:
  - At rising clk with clr=0, we=1, wn!=0: register[wn] <= d and wr_cnt <= wr_cnt+1.
  - wr_cnt wraps 0xFFFF -> 0x0000.
  - we=0: no state change.
- Read (combinational, zero latency):
  - qa = 0 if rna=0.
  - Else qa = d if (we=1 and wn=rna and clr=0).
  - Else qa = register[rna].
  - qb identical using rnb.
- Simultaneous events:
  - rna=rnb=wn with we=1: both ports return d.
  - Bypass is purely combinational from we/wn/d; a read in the cycle after the write sees the stored value, identical to d.
- Debug port:
  - dbg_q = register[dbg_rn], or 0 for dbg_rn=0.
  - No bypass: reflects committed state only.
- No X propagation: every register is defined from reset onward.

Test Plan:
1. Reset mid-operation:
   - Write 0xDEADBEEF to r5.
   - Assert clr between clock edges with we=1, wn=5, d=0x12345678 held.
   - Required: qa (rna=5)=0 immediately; wr_cnt=0.
   - After clr drops and one edge with we=1, wn=5, d=0x12345678: dbg_q (dbg_rn=5)=0x12345678, wr_cnt=1.
2. r0 immutability:
   - Drive we=1, wn=0, d=0xFFFFFFFF for 3 edges, rna=0.
   - Required: qa=0 throughout, dbg_q(0)=0, wr_cnt unchanged.
3. Bypass:
   - Preload r7=0x00000011.
   - Drive we=1, wn=7, d=0x00000022, rna=rnb=7.
   - Required before the edge: qa=qb=0x00000022, dbg_q(7)=0x00000011.
   - Required after the edge with we=0: qa=qb=dbg_q=0x00000022.
4. Independent ports:
   - Preload r1..r31 with value 0x1000+n.
   - Sweep rna=n, rnb=31-n with we=0.
   - Required: qa=0x1000+n (0 for n=0), qb=0x1000+(31-n) (0 for 31-n=0).
5. Write enable gating:
   - Drive we=0, wn=9, d=0xCAFEF00D, rna=9.
   - Required: qa stays at the prior value 0x00001009, no commit after the edge, wr_cnt unchanged.
6. Counter wrap:
   - Perform 65536 writes to r3 with d = loop index.
   - Required: wr_cnt=0x0000 at the end; r3=0x0000FFFF.
